// File: rtl/det_result_fifo_if.sv
// Handshake bundle between the determinant datapath, the result FIFO and its consumer.
interface det_result_fifo_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        out_singular;
    logic        out_negative;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_singular, out_negative
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_singular, out_negative
    );
endinterface

// File: rtl/det_result_fifo.sv
// First-word fall-through FIFO for 16-bit determinant results with singular/negative decode.
// Optional DET_SINGULAR_COUNT_EN adds a saturating count of accepted zero results.
module det_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    det_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
`ifdef DET_SINGULAR_COUNT_EN
    ,output logic [7:0]              singular_count
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_overflow;
    logic [15:0]     r_mem [DEPTH];
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic [15:0]     w_head;

    // Occupancy state register and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_EMPTY;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push)                      r_wr_ptr   <= r_wr_ptr + PW'(1);
            if (w_pop)                       r_rd_ptr   <= r_rd_ptr + PW'(1);
            if (bus.in_valid && !w_in_ready) r_overflow <= 1'b1;
        end
    end

    // Handshake decode and next occupancy; in FULL a pop frees space only for the next edge
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            S_EMPTY:   begin w_in_ready = 1'b1; w_out_valid = 1'b0; end
            S_PARTIAL: begin w_in_ready = 1'b1; w_out_valid = 1'b1; end
            S_FULL:    begin w_in_ready = 1'b0; w_out_valid = 1'b1; end
            default:   begin w_in_ready = 1'b1; w_out_valid = 1'b0; end
        endcase
        w_push = bus.in_valid && w_in_ready;
        w_pop  = w_out_valid && bus.out_ready;
        if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
        if (w_count_nxt == '0)              w_state_nxt = S_EMPTY;
        else if (w_count_nxt == CW'(DEPTH)) w_state_nxt = S_FULL;
        else                                w_state_nxt = S_PARTIAL;
    end

    // Storage is not reset; the head is masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
    end

    assign w_head           = w_out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = w_head;
    assign bus.out_singular = w_out_valid && (w_head == 16'h0000);
    assign bus.out_negative = w_out_valid && w_head[15];
    assign count            = r_count;
    assign overflow_err     = r_overflow;

`ifdef DET_SINGULAR_COUNT_EN
    logic [7:0] r_singular_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_singular_count <= '0;
        end else if (w_push && (bus.in_data == 16'h0000) && (r_singular_count != 8'hFF)) begin
            r_singular_count <= r_singular_count + 8'd1;
        end
    end

    assign singular_count = r_singular_count;
`endif
endmodule

// File: tb/tb_det_result_fifo.sv
// Directed and randomized checks of det_result_fifo against a queue-based reference model.
module tb_det_result_fifo;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic [$clog2(DEPTH):0] count;
    logic overflow_err;
`ifdef DET_SINGULAR_COUNT_EN
    logic [7:0] singular_count;
`endif

    det_result_fifo_if bus ();

    det_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count        (count),
        .overflow_err (overflow_err)
`ifdef DET_SINGULAR_COUNT_EN
        ,.singular_count (singular_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents in push order, sticky overflow, saturating zero count
    logic [15:0] q[$];
    bit          m_ovf;
    int          m_sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] eh;
        bit          ev;
        ev = (q.size() > 0);
        eh = ev ? q[0] : 16'h0000;
        chk({tag, "_in_ready"},  32'(bus.in_ready),     32'(q.size() < DEPTH));
        chk({tag, "_out_valid"}, 32'(bus.out_valid),    32'(ev));
        chk({tag, "_out_data"},  32'(bus.out_data),     32'(eh));
        chk({tag, "_singular"},  32'(bus.out_singular), 32'(ev && eh == 16'h0000));
        chk({tag, "_negative"},  32'(bus.out_negative), 32'(ev && eh[15]));
        chk({tag, "_count"},     32'(count),            32'(q.size()));
        chk({tag, "_overflow"},  32'(overflow_err),     32'(m_ovf));
`ifdef DET_SINGULAR_COUNT_EN
        chk({tag, "_sing_cnt"},  32'(singular_count),   32'(m_sc));
`endif
    endtask

    // One clock: apply inputs, predict from the model, advance, compare
    task automatic cycle(input string tag, input bit iv, input logic [15:0] id, input bit ordy);
        bit push;
        bit pop;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        push = iv && (q.size() < DEPTH);
        pop  = ordy && (q.size() > 0);
        if (iv && q.size() == DEPTH) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) begin
            q.push_back(id);
            if (id == 16'h0000 && m_sc < 255) m_sc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_all(tag);
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_sc  = 0;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return v | 16'h8000;
            default: return v;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        rst = 1'b1;
        model_clear();
        #1;
        do_reset();

        // Three results held back, then drained in order
        cycle("p1", 1'b1, 16'h0005, 1'b0);
        chk("p1_lat_valid", 32'(bus.out_valid), 32'd1);
        cycle("p2", 1'b1, 16'hFFFD, 1'b0);
        cycle("p3", 1'b1, 16'h0000, 1'b0);
        chk("r31_count", 32'(count), 32'd3);
        chk("r31_head",  32'(bus.out_data), 32'h0005);
        chk("r31_neg",   32'(bus.out_negative), 32'd0);
        chk("r31_sing",  32'(bus.out_singular), 32'd0);
        cycle("d1", 1'b0, 16'h0000, 1'b1);
        chk("r32_head2", 32'(bus.out_data), 32'hFFFD);
        chk("r32_neg2",  32'(bus.out_negative), 32'd1);
        cycle("d2", 1'b0, 16'h0000, 1'b1);
        chk("r32_head3", 32'(bus.out_data), 32'h0000);
        chk("r32_sing3", 32'(bus.out_singular), 32'd1);
        cycle("d3", 1'b0, 16'h0000, 1'b1);
        chk("r32_empty_cnt", 32'(count), 32'd0);
        chk("r32_empty_vld", 32'(bus.out_valid), 32'd0);

        // Overflow on fifth push; sticky through drain
        for (int i = 0; i < 5; i++) cycle("ovf_fill", 1'b1, rand_data(), 1'b0);
        chk("r33_in_ready", 32'(bus.in_ready), 32'd0);
        chk("r33_ovf",      32'(overflow_err), 32'd1);
        for (int i = 0; i < 5; i++) cycle("ovf_drain", 1'b0, 16'h0000, 1'b1);
        chk("r33_ovf_sticky", 32'(overflow_err), 32'd1);

        // Full with simultaneous offer: only the pop happens
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle("full_fill", 1'b1, 16'(16'h0100 + i), 1'b0);
        cycle("full_both", 1'b1, 16'hBEEF, 1'b1);
        chk("r34_full_cnt", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("r34_no_beef", 32'(bus.out_data == 16'hBEEF), 32'd0);
            cycle("full_drain", 1'b0, 16'h0000, 1'b1);
        end
        cycle("empty_both", 1'b1, 16'h7123, 1'b1);
        chk("r34_empty_cnt", 32'(count), 32'd1);
        chk("r34_empty_vld", 32'(bus.out_valid), 32'd1);
        cycle("empty_drain", 1'b0, 16'h0000, 1'b1);

        // Push/pop pairs in PARTIAL wrap both pointers
        cycle("pp_pre1", 1'b1, rand_data(), 1'b0);
        cycle("pp_pre2", 1'b1, rand_data(), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("pp_pair", 1'b1, rand_data(), 1'b1);
            chk("r35_count", 32'(count), 32'd2);
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            cycle("rand", 1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 2) != 0));

        // Async reset between edges at occupancy two
        do_reset();
        cycle("ar_p1", 1'b1, 16'h1111, 1'b0);
        cycle("ar_p2", 1'b1, 16'h2222, 1'b0);
        chk("r36_pre_cnt", 32'(count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("r36_async_vld", 32'(bus.out_valid), 32'd0);
        chk("r36_async_cnt", 32'(count), 32'd0);
        chk("r36_async_data", 32'(bus.out_data), 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("ar_first", 1'b1, 16'h3333, 1'b0);
        chk("r36_first_head", 32'(bus.out_data), 32'h3333);
        cycle("ar_second", 1'b1, 16'h4444, 1'b1);
        chk("r36_second_head", 32'(bus.out_data), 32'h4444);

`ifdef DET_SINGULAR_COUNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            d = 16'h0000;
            cycle("sc_zero", 1'b1, d, 1'b1);
        end
        chk("r36_sing_sat", 32'(singular_count), 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/det_result_fifo.md
DET_RESULT_FIFO -- requirements
Module: det_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 16-bit result entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset; asynchronous, active-low (0 = reset).
REQ-004 The block SHALL have port in_valid, input, 1, meaning the upstream determinant datapath presents a finished a*d-b*c result this cycle.
REQ-005 The block SHALL have port in_data, input, 16, meaning the determinant result in two's complement.
REQ-006 The block SHALL have port in_ready, output, 1, meaning an entry is free (not full).
REQ-007 The block SHALL have port out_valid, output, 1, meaning the head entry is valid.
REQ-008 The block SHALL have port out_data, output, 16, meaning the head entry.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the head this cycle.
REQ-010 The block SHALL have port out_singular, output, 1, meaning out_valid and out_data == 0.
REQ-011 The block SHALL have port out_negative, output, 1, meaning out_valid and out_data[15] == 1.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1, meaning the current occupancy (0..DEPTH).
REQ-013 The block SHALL have port overflow_err, output, 1, meaning a sticky flag set when a result was offered while the FIFO was full.

Function
REQ-014 A push SHALL occur on a clk edge where in_valid=1 and in_ready=1; in_data is then written at the write pointer.
REQ-015 A pop SHALL occur on a clk edge where out_valid=1 and out_ready=1; the read pointer then advances.
REQ-016 The block SHALL implement three occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); in_ready=0 only in FULL, out_valid=0 only in EMPTY.
REQ-017 The FIFO SHALL be first-word fall-through: a value pushed at edge N appears on out_data with out_valid=1 immediately after edge N when the FIFO was EMPTY, so write-to-output latency is 1 cycle.
REQ-018 out_data SHALL hold its value while out_ready=0; results SHALL leave in push order.
REQ-019 Both pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication.
REQ-020 A simultaneous push and pop in PARTIAL SHALL leave count unchanged and perform both operations.
REQ-021 In EMPTY with in_valid=1 and out_ready=1, only the push SHALL occur; count becomes 1.
REQ-022 In FULL with in_valid=1 and out_ready=1, only the pop SHALL occur, because in_ready=0; count becomes DEPTH-1 and the offered result is dropped.
REQ-023 overflow_err SHALL be set on any edge where in_valid=1 and in_ready=0, and SHALL clear only on reset.
REQ-024 out_singular and out_negative SHALL be combinational decodes of the head entry, and SHALL be 0 when out_valid=0.

Reset
REQ-025 rst=0 SHALL immediately clear both pointers, count, and overflow_err, and the singular counter if present, independent of clk.
REQ-026 During reset the outputs SHALL be: in_ready=1, out_valid=0, out_data=0, out_singular=0, out_negative=0, count=0, overflow_err=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; the first push after rst returns to 1 SHALL land in entry 0.
REQ-028 The storage array need not be cleared, but out_data SHALL read 0 whenever out_valid=0.

Configuration
REQ-029 When macro DET_SINGULAR_COUNT_EN is defined, the block SHALL add output singular_count, 8 bits, which increments on each accepted push with in_data == 0 and saturates at 255.
REQ-030 When DET_SINGULAR_COUNT_EN is undefined, the singular_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then push 16'h0005, 16'hFFFD, 16'h0000 on consecutive cycles with out_ready=0 -> count=3; head 16'h0005 with out_negative=0 and out_singular=0.
REQ-032 Continuing REQ-031, hold out_ready=1 for three cycles -> out_data is 0005, FFFD (out_negative=1), 0000 (out_singular=1); then count=0 and out_valid=0.
REQ-033 Push 5 values with DEPTH=4 and out_ready=0 -> the 5th is dropped, in_ready=0, overflow_err=1, and overflow_err stays 1 after the FIFO drains.
REQ-034 From FULL, in_valid=1 and out_ready=1 for one cycle -> count=3 and the offered value never appears; from EMPTY, the same stimulus -> count=1 and out_valid=1 on the next cycle.
REQ-035 Run 10 push/pop pairs in PARTIAL -> the pointers wrap and the output order matches the input order exactly.
REQ-036 Drop rst asynchronously between clk edges while count=2 -> out_valid=0 and count=0 immediately; with DET_SINGULAR_COUNT_EN defined, 300 zero pushes -> singular_count=255.
